// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract built on one 4-bit ripple-carry slice.
// One nibble per clock, LSB nibble first, with valid/ready on both sides.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; ready never depends combinationally on valid.
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, c_out_q, ovf_q;
  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_c, ripple_c, last;

  assign start_ready  = (state == IDLE);
  assign busy         = (state == RUN) || (state == DONE);
  assign result_valid = (state == DONE);
  assign sum          = sum_q;
  assign c_out        = c_out_q;
  assign overflow     = ovf_q;
  assign last         = (idx == IW'(NIBBLES - 1));

  // The shared 4-bit ripple-carry slice, fed from the current nibble.
  always_comb begin
    slice_a  = a_q[4*idx +: 4];
    slice_b  = b_q[4*idx +: 4];
    slice_s  = '0;
    ripple_c = carry_q;
    for (int j = 0; j < 4; j++) begin
      slice_s[j] = slice_a[j] ^ slice_b[j] ^ ripple_c;
      ripple_c   = (slice_a[j] & slice_b[j]) | (ripple_c & (slice_a[j] ^ slice_b[j]));
    end
    slice_c = ripple_c;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            // Subtraction is A + ~B + 1: invert B once and seed the carry.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | c_in;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[4*idx +: 4] <= slice_s;
          carry_q           <= slice_c;
          idx               <= last ? '0 : idx + IW'(1);
          if (last) begin
            c_out_q <= slice_c;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed steps then random back-to-back
// operations checked against an integer-arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];

  nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow), .busy(busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Returns {c_out, overflow, sum} from plain unsigned/signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sv, input logic cv);
    longint ua, ub, sa, sb, full, sres;
    logic co, ov;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sv) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(cv);
      co   = (full >= (longint'(1) << W));
      sres = sa + sb + longint'(cv);
    end
    ov = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
    return {co, ov, full[W-1:0]};
  endfunction

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] outs();
    return {c_out, overflow, sum};
  endfunction

  function automatic logic [W+1:0] flags();
    return {{(W-1){1'b0}}, start_ready, busy, result_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation, accepts it on the next edge, then scrambles inputs.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic cv);
    a = av; b = bv; sub = sv; c_in = cv;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic sv, input logic cv, input logic [W+1:0] exp);
    int lat;
    logic [W+1:0] held;
    start_op(av, bv, sv, cv);
    check({tag, "_run_flags"}, flags(), (W+2)'(3'b010));
    wait_result(lat);
    check({tag, "_latency"}, (W+2)'(lat), (W+2)'(NIB));
    check({tag, "_result"}, outs(), exp);
    held = outs();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_idle_flags"}, flags(), (W+2)'(3'b100));
    check({tag, "_held"}, outs(), held);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, seen, issued, done, cyc, last_acc;
    logic [W+1:0] held;

    // Reset state
    #3;
    check("reset_flags", flags(), (W+2)'(3'b100));
    check("reset_outs", outs(), '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Add wrap and signed overflow cases
    run_directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    run_directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    run_directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});

    // Borrow with c_in ignored; partial sum shows only nibble 0 written
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    check("borrow_sum_cleared", outs(), '0);
    tick();
    check("borrow_partial", outs(), {2'b00, 16'h000E});
    wait_result(lat);
    check("borrow_latency", (W+2)'(lat), (W+2)'(NIB - 1));
    check("borrow_result", outs(), {1'b0, 1'b0, 16'hFFFE});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Backpressure: result held, start pulses ignored, single handshake
    start_op(16'h1357, 16'h2468, 1'b0, 1'b1);
    wait_result(lat);
    check("bp_latency", (W+2)'(lat), (W+2)'(NIB));
    check("bp_result", outs(), {2'b00, 16'h37C0});
    held = outs();
    for (int i = 0; i < 3; i++) begin
      start_valid = (i != 1);
      a = W'($urandom); b = W'($urandom);
      tick();
      check("bp_hold_outs", outs(), held);
      check("bp_hold_flags", flags(), (W+2)'(3'b011));
    end
    start_valid = 1'b1;
    result_ready = 1'b1;
    tick();
    start_valid = 1'b0;
    result_ready = 1'b0;
    check("bp_release_flags", flags(), (W+2)'(3'b100));
    check("bp_release_outs", outs(), held);
    tick();
    check("bp_still_idle", flags(), (W+2)'(3'b100));

    // Reset in the middle of RUN
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", flags(), (W+2)'(3'b100));
    check("midrst_outs", outs(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid === 1'b1) seen++;
    end
    check("midrst_no_result", (W+2)'(seen), '0);
    run_directed("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2345});

    // Back-to-back random operations, both handshakes held open
    issued = 0; done = 0; cyc = 0; last_acc = -1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    start_valid = 1'b1;
    result_ready = 1'b1;
    while (done < 200 && cyc < 3000) begin
      if (issued == 200) start_valid = 1'b0;
      if (result_valid === 1'b1) begin
        if (exp_q.size() > 0) check("b2b_result", outs(), exp_q.pop_front());
        else check("b2b_spurious_result", (W+2)'(1), '0);
        done++;
      end
      if (start_ready === 1'b1 && start_valid) begin
        if (last_acc >= 0) check("b2b_period", (W+2)'(cyc - last_acc), (W+2)'(NIB + 2));
        last_acc = cyc;
        exp_q.push_back(model(a, b, sub, c_in));
        issued++;
      end else begin
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      end
      tick();
      cyc++;
    end
    start_valid = 1'b0;
    result_ready = 1'b0;
    check("b2b_done_count", (W+2)'(done), (W+2)'(200));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
